// File: rtl/bfly_pkg.sv
// bfly_pkg: shared state encoding, defaults and sequencing helper for the butterfly feeder.
package bfly_pkg;
  localparam int DATA_W   = 8;
  localparam int HOLD_CYC = 16;
  localparam int CALC_CYC = 16;

  typedef enum logic [3:0] {
    IDLE, W_LO, W_HI, B_LO, B_HI, A_LO, A_HI, IMY_LO, REZ_HI, IMZ_LO, FIN_HI
  } feeder_state_t;

  function automatic feeder_state_t nextState(input feeder_state_t s);
    return s == FIN_HI ? IDLE : feeder_state_t'(s + 4'd1);
  endfunction
endpackage

// File: rtl/bfly_phase_timer.sv
// bfly_phase_timer: loadable down-counter that flags the final cycle of a phase.
module bfly_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             last
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) count <= '0;
    else if (load) count <= loadVal;
    else if (count != '0) count <= count - CNT_W'(1);

  assign last = count == CNT_W'(1);
endmodule

// File: rtl/bfly_feeder.sv
// bfly_feeder: drives the butterfly controller's ReadyIn toggle handshake and operand bus.
// Define BFLY_FEEDER_CAPTURE_EN to add ResultIn and the four sampled result registers.
module bfly_feeder #(
  parameter int DATA_W   = bfly_pkg::DATA_W,
  parameter int HOLD_CYC = bfly_pkg::HOLD_CYC,
  parameter int CALC_CYC = bfly_pkg::CALC_CYC
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              start,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] a_in,
`ifdef BFLY_FEEDER_CAPTURE_EN
  input  logic [DATA_W-1:0] ResultIn,
  output logic [DATA_W-1:0] re_y,
  output logic [DATA_W-1:0] im_y,
  output logic [DATA_W-1:0] re_z,
  output logic [DATA_W-1:0] im_z,
`endif
  output logic              ReadyOut,
  output logic [DATA_W-1:0] DataOut,
  output logic              busy,
  output logic              done
);
  import bfly_pkg::*;

  localparam int CNT_W = $clog2(HOLD_CYC + CALC_CYC + 1);

  if (HOLD_CYC < 4) begin : gBadHold
    $error("bfly_feeder: HOLD_CYC must be >= 4");
  end
  if (CALC_CYC < 8) begin : gBadCalc
    $error("bfly_feeder: CALC_CYC must be >= 8");
  end

  feeder_state_t     state, nxt;
  logic [DATA_W-1:0] wReg, bReg, aReg;
  logic [CNT_W-1:0]  nxtLen;
  logic              last, accept, advance;

  // done doubles as the guard that ignores start on the IDLE re-entry cycle
  assign accept  = state == IDLE && start && !done;
  assign advance = accept || (state != IDLE && last);
  assign nxt     = nextState(state);
  assign nxtLen  = nxt == IDLE ? '0 :
                   (nxt == B_HI || nxt == A_HI) ? CNT_W'(HOLD_CYC + CALC_CYC) : CNT_W'(HOLD_CYC);

  bfly_phase_timer #(.CNT_W(CNT_W)) uTimer (
    .Clock   (Clock),
    .nReset  (nReset),
    .load    (advance),
    .loadVal (nxtLen),
    .last    (last)
  );

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      state    <= IDLE;
      wReg     <= '0;
      bReg     <= '0;
      aReg     <= '0;
      ReadyOut <= 1'b1;
      DataOut  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= state == FIN_HI && last;
      if (accept) {wReg, bReg, aReg} <= {w_in, b_in, a_in};
      if (advance) begin
        state    <= nxt;
        ReadyOut <= !(nxt inside {W_LO, B_LO, A_LO, IMY_LO, IMZ_LO});
        DataOut  <= accept ? w_in : nxt == IDLE ? '0 : nxt < B_LO ? wReg : nxt < A_LO ? bReg : aReg;
        busy     <= nxt != IDLE;
      end
    end

`ifdef BFLY_FEEDER_CAPTURE_EN
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      re_y <= '0;
      im_y <= '0;
      re_z <= '0;
      im_z <= '0;
    end else if (last) begin
      if (state == A_HI) re_y <= ResultIn;
      if (state == IMY_LO) im_y <= ResultIn;
      if (state == REZ_HI) re_z <= ResultIn;
      if (state == IMZ_LO) im_z <= ResultIn;
    end
`endif
endmodule

// File: tb/tb_bfly_feeder.sv
// tb_bfly_feeder: table vectors plus randomized transactions against a phase-duration model.
module tb_bfly_feeder;
  localparam int H = 4;
  localparam int C = 8;
  localparam int T = 10 * H + 2 * C;

  typedef struct {
    int         cyc;
    logic       rdy;
    logic [7:0] data;
    logic       busy;
    logic       done;
  } vec_t;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] w_in = '0, b_in = '0, a_in = '0;
  logic       ReadyOut, busy, done;
  logic [7:0] DataOut;
`ifdef BFLY_FEEDER_CAPTURE_EN
  logic [7:0] ResultIn = '0;
  logic [7:0] re_y, im_y, re_z, im_z;
`endif

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  bfly_feeder #(.DATA_W(8), .HOLD_CYC(H), .CALC_CYC(C)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .start    (start),
    .w_in     (w_in),
    .b_in     (b_in),
    .a_in     (a_in),
`ifdef BFLY_FEEDER_CAPTURE_EN
    .ResultIn (ResultIn),
    .re_y     (re_y),
    .im_y     (im_y),
    .re_z     (re_z),
    .im_z     (im_z),
`endif
    .ReadyOut (ReadyOut),
    .DataOut  (DataOut),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Phase index 0..9 (W_LO..FIN_HI) of cycle k after the start cycle, -1 outside the transaction
  function automatic int phaseOf(input int k);
    int acc = 0;
    if (k < 1 || k > T) return -1;
    for (int p = 0; p < 10; p++) begin
      acc += (p == 3 || p == 5) ? H + C : H;
      if (k <= acc) return p;
    end
    return -1;
  endfunction

  task automatic setInputs(input int k, input logic [3:0][7:0] rv, input logic spur);
    int p;
    p = phaseOf(k);
    start = spur;
    w_in = 8'($urandom);
    b_in = 8'($urandom);
    a_in = 8'($urandom);
`ifdef BFLY_FEEDER_CAPTURE_EN
    ResultIn = (p >= 5 && p <= 8) ? rv[p-5] : 8'($urandom);
`else
    if (p > 99 && rv[0] == 8'h00) start = spur;
`endif
  endtask

  task automatic checkResults(input string tag, input logic [3:0][7:0] rv);
`ifdef BFLY_FEEDER_CAPTURE_EN
    check({tag, " re_y"}, {24'd0, re_y}, {24'd0, rv[0]});
    check({tag, " im_y"}, {24'd0, im_y}, {24'd0, rv[1]});
    check({tag, " re_z"}, {24'd0, re_z}, {24'd0, rv[2]});
    check({tag, " im_z"}, {24'd0, im_z}, {24'd0, rv[3]});
`else
    if (tag.len() > 999) check(tag, {24'd0, rv[0]}, 32'd0);
`endif
  endtask

  // One full transaction checked every cycle against the phase model; s1/s2 are spurious start cycles
  task automatic runTxn(input logic [7:0] w, input logic [7:0] b, input logic [7:0] a,
                        input int s1, input int s2);
    logic [3:0][7:0] rv;
    int p;
    logic expRdy, expBusy, expDone;
    logic [7:0] expData;
    for (int i = 0; i < 4; i++) rv[i] = 8'($urandom);
    start = 1'b1;
    w_in = w;
    b_in = b;
    a_in = a;
    tick;
    for (int k = 1; k <= T + 2; k++) begin
      setInputs(k, rv, k == s1 || k == s2);
      p = phaseOf(k);
      expRdy  = p < 0 ? 1'b1 : p[0];
      expData = p < 0 ? 8'h00 : p < 2 ? w : p < 4 ? b : a;
      expBusy = p >= 0;
      expDone = k == T + 1;
      check($sformatf("cyc%0d ReadyOut", k), {31'd0, ReadyOut}, {31'd0, expRdy});
      check($sformatf("cyc%0d DataOut", k), {24'd0, DataOut}, {24'd0, expData});
      check($sformatf("cyc%0d busy", k), {31'd0, busy}, {31'd0, expBusy});
      check($sformatf("cyc%0d done", k), {31'd0, done}, {31'd0, expDone});
      tick;
    end
    start = 1'b0;
    checkResults("txn", rv);
  endtask

  initial begin
    vec_t tab[16];
    logic [3:0][7:0] rvT;

    tab = '{'{1, 0, 8'h12, 1, 0}, '{4, 0, 8'h12, 1, 0}, '{5, 1, 8'h12, 1, 0}, '{8, 1, 8'h12, 1, 0},
            '{9, 0, 8'h34, 1, 0}, '{12, 0, 8'h34, 1, 0}, '{13, 1, 8'h34, 1, 0}, '{24, 1, 8'h34, 1, 0},
            '{25, 0, 8'h56, 1, 0}, '{28, 0, 8'h56, 1, 0}, '{29, 1, 8'h56, 1, 0}, '{40, 1, 8'h56, 1, 0},
            '{41, 0, 8'h56, 1, 0}, '{56, 1, 8'h56, 1, 0}, '{57, 1, 8'h00, 0, 1}, '{58, 1, 8'h00, 0, 0}};
    rvT = {8'hD4, 8'hC3, 8'hB2, 8'hA1};

    tick;
    tick;
    check("reset ReadyOut", {31'd0, ReadyOut}, 32'd1);
    check("reset DataOut", {24'd0, DataOut}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    checkResults("reset", '0);
    nReset = 1'b1;
    tick;

    start = 1'b1;
    w_in = 8'h12;
    b_in = 8'h34;
    a_in = 8'h56;
    tick;
    for (int k = 1; k <= 58; k++) begin
      setInputs(k, rvT, 1'b0);
      foreach (tab[i])
        if (tab[i].cyc == k) begin
          check($sformatf("tab%0d ReadyOut", k), {31'd0, ReadyOut}, {31'd0, tab[i].rdy});
          check($sformatf("tab%0d DataOut", k), {24'd0, DataOut}, {24'd0, tab[i].data});
          check($sformatf("tab%0d busy", k), {31'd0, busy}, {31'd0, tab[i].busy});
          check($sformatf("tab%0d done", k), {31'd0, done}, {31'd0, tab[i].done});
        end
      tick;
    end
    checkResults("tab", rvT);

    runTxn(8'hAB, 8'hCD, 8'hEF, 20, T + 1);
    for (int n = 0; n < 3; n++)
      runTxn(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(1, T)), T + 1);

    start = 1'b1;
    w_in = 8'h77;
    b_in = 8'h88;
    a_in = 8'h99;
    tick;
    start = 1'b0;
    for (int k = 1; k < 30; k++) tick;
    #2;
    nReset = 1'b0;
    #1;
    check("midrst ReadyOut", {31'd0, ReadyOut}, 32'd1);
    check("midrst DataOut", {24'd0, DataOut}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    checkResults("midrst", '0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("inrst%0d done", k), {31'd0, done}, 32'd0);
    end
    nReset = 1'b1;
    tick;
    check("postrst busy", {31'd0, busy}, 32'd0);
    runTxn(8'h5A, 8'hA5, 8'h3C, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
